// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants: register index names, default widths and
// the register-index type.
package mips_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int ADDR_WIDTH_DEF = 5;

  localparam int REG_ZERO = 0;
  localparam int REG_RA   = 31;

  typedef logic [ADDR_WIDTH_DEF-1:0] reg_idx_t;

endpackage

// File: rtl/reg_file.sv
// Two-read / one-write MIPS register file with a non-bypassed debug read port.
// Optional write-first forwarding on rega/regb is enabled by REGFILE_BYPASS_EN.
module reg_file
  import mips_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] rs_addr,
  input  logic [ADDR_WIDTH-1:0] rt_addr,
  output logic [DATA_WIDTH-1:0] rega,
  output logic [DATA_WIDTH-1:0] regb,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  output logic [DATA_WIDTH-1:0] dbg_data
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = ADDR_WIDTH'(REG_ZERO);

  logic [DATA_WIDTH-1:0] regs [DEPTH];
  logic                  wr_ok;

  // Entry 0 is never written, so the array slot for $0 stays at its reset value.
  assign wr_ok = we && (wr_addr != ZERO_IDX);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_ok) begin
      regs[wr_addr] <= wr_data;
    end
  end

  function automatic logic [DATA_WIDTH-1:0] stored(input logic [ADDR_WIDTH-1:0] addr);
    stored = (addr == ZERO_IDX) ? '0 : regs[addr];
  endfunction

`ifdef REGFILE_BYPASS_EN
  function automatic logic bypass_hit(input logic [ADDR_WIDTH-1:0] addr);
    bypass_hit = !rst && wr_ok && (wr_addr == addr);
  endfunction

  always_comb begin
    rega = stored(rs_addr);
    regb = stored(rt_addr);
    if (bypass_hit(rs_addr)) rega = wr_data;
    if (bypass_hit(rt_addr)) regb = wr_data;
  end
`else
  always_comb begin
    rega = stored(rs_addr);
    regb = stored(rt_addr);
  end
`endif

  assign dbg_data = stored(dbg_addr);

endmodule

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file; expectations for the same-cycle
// read/write case follow REGFILE_BYPASS_EN.
module tb_reg_file;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk;
  logic          rst;
  logic [AW-1:0] rs_addr;
  logic [AW-1:0] rt_addr;
  logic [DW-1:0] rega;
  logic [DW-1:0] regb;
  logic          we;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_data;

  int checks;
  int passes;

  reg_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .rs_addr  (rs_addr),
    .rt_addr  (rt_addr),
    .rega     (rega),
    .regb     (regb),
    .we       (we),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on the falling edge; outputs are sampled 1ns later.
  task automatic write_reg(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    we = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    we = 1'b0; wr_addr = '0; wr_data = '0;
  endtask

  task automatic set_reads(input logic [AW-1:0] a, input logic [AW-1:0] b,
                           input logic [AW-1:0] d);
    rs_addr = a; rt_addr = b; dbg_addr = d;
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    set_reads(5'd5, 5'd31, 5'd17);
    checks++; if (rega !== 32'h0) $display("FAIL reset_rega got %h exp %h", rega, 32'h0); else passes++;
    checks++; if (regb !== 32'h0) $display("FAIL reset_regb got %h exp %h", regb, 32'h0); else passes++;
    checks++; if (dbg_data !== 32'h0) $display("FAIL reset_dbg got %h exp %h", dbg_data, 32'h0); else passes++;
    write_reg(5'd5, 32'hDEADBEEF);
    set_reads(5'd5, 5'd0, 5'd5);
    checks++; if (dbg_data !== 32'hDEADBEEF) $display("FAIL pre_reset_dbg got %h exp %h", dbg_data, 32'hDEADBEEF); else passes++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    set_reads(5'd5, 5'd0, 5'd5);
    checks++; if (dbg_data !== 32'h0) $display("FAIL reset_clear_dbg got %h exp %h", dbg_data, 32'h0); else passes++;
    checks++; if (rega !== 32'h0) $display("FAIL reset_clear_rega got %h exp %h", rega, 32'h0); else passes++;
  endtask

  task automatic test_write_read;
    write_reg(5'd1, 32'd10);
    write_reg(5'd2, 32'd20);
    set_reads(5'd1, 5'd2, 5'd1);
    checks++; if (rega !== 32'd10) $display("FAIL wr_rega got %0d exp %0d", rega, 10); else passes++;
    checks++; if (regb !== 32'd20) $display("FAIL wr_regb got %0d exp %0d", regb, 20); else passes++;
    checks++; if (rega + regb !== 32'd30) $display("FAIL alu_add got %0d exp %0d", rega + regb, 30); else passes++;
    set_reads(5'd2, 5'd1, 5'd2);
    checks++; if (rega !== 32'd20 || regb !== 32'd10) $display("FAIL swap_ports got %0d/%0d exp 20/10", rega, regb); else passes++;
  endtask

  task automatic test_zero;
    write_reg(5'd0, 32'hFFFFFFFF);
    set_reads(5'd0, 5'd0, 5'd0);
    checks++; if (rega !== 32'h0) $display("FAIL zero_rega got %h exp %h", rega, 32'h0); else passes++;
    checks++; if (regb !== 32'h0) $display("FAIL zero_regb got %h exp %h", regb, 32'h0); else passes++;
    checks++; if (dbg_data !== 32'h0) $display("FAIL zero_dbg got %h exp %h", dbg_data, 32'h0); else passes++;
  endtask

  task automatic test_same_cycle;
    logic [DW-1:0] exp_pre;
`ifdef REGFILE_BYPASS_EN
    exp_pre = 32'd9;
`else
    exp_pre = 32'd7;
`endif
    write_reg(5'd3, 32'd7);
    @(negedge clk);
    we = 1'b1; wr_addr = 5'd3; wr_data = 32'd9;
    set_reads(5'd3, 5'd3, 5'd3);
    checks++; if (rega !== exp_pre) $display("FAIL rw_pre_rega got %0d exp %0d", rega, exp_pre); else passes++;
    checks++; if (regb !== exp_pre) $display("FAIL rw_pre_regb got %0d exp %0d", regb, exp_pre); else passes++;
    checks++; if (dbg_data !== 32'd7) $display("FAIL rw_pre_dbg got %0d exp %0d", dbg_data, 7); else passes++;
    @(negedge clk);
    we = 1'b0; wr_addr = 5'd3; wr_data = 32'hBAD0BAD0;
    #1;
    checks++; if (rega !== 32'd9) $display("FAIL rw_post_rega got %0d exp %0d", rega, 9); else passes++;
    @(negedge clk);
    #1;
    checks++; if (dbg_data !== 32'd9) $display("FAIL we0_no_write got %h exp %h", dbg_data, 32'd9); else passes++;
    wr_addr = '0; wr_data = '0;
  endtask

  task automatic test_reset_collision;
    write_reg(5'd4, 32'h11);
    rst = 1'b1; we = 1'b1; wr_addr = 5'd4; wr_data = 32'h55;
    set_reads(5'd4, 5'd4, 5'd4);
    checks++; if (rega !== 32'h11) $display("FAIL rst_no_bypass got %h exp %h", rega, 32'h11); else passes++;
    @(negedge clk);
    rst = 1'b0; we = 1'b0; wr_addr = '0; wr_data = '0;
    #1;
    checks++; if (dbg_data !== 32'h0) $display("FAIL rst_wins got %h exp %h", dbg_data, 32'h0); else passes++;
  endtask

  task automatic test_boundary;
    write_reg(5'd31, 32'h12345678);
    set_reads(5'd31, 5'd31, 5'd30);
    checks++; if (rega !== 32'h12345678) $display("FAIL ra_rega got %h exp %h", rega, 32'h12345678); else passes++;
    checks++; if (regb !== 32'h12345678) $display("FAIL ra_regb got %h exp %h", regb, 32'h12345678); else passes++;
    checks++; if (dbg_data !== 32'h0) $display("FAIL r30_clear got %h exp %h", dbg_data, 32'h0); else passes++;
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    we = 1'b1; wr_addr = 5'd6; wr_data = 32'hA6;
    @(negedge clk);
    wr_addr = 5'd7; wr_data = 32'hB7;
    @(negedge clk);
    wr_addr = 5'd6; wr_data = 32'hC6;
    @(negedge clk);
    we = 1'b0; wr_addr = '0; wr_data = '0;
    set_reads(5'd6, 5'd7, 5'd31);
    checks++; if (rega !== 32'hC6) $display("FAIL b2b_r6 got %h exp %h", rega, 32'hC6); else passes++;
    checks++; if (regb !== 32'hB7) $display("FAIL b2b_r7 got %h exp %h", regb, 32'hB7); else passes++;
    checks++; if (dbg_data !== 32'h12345678) $display("FAIL b2b_r31 got %h exp %h", dbg_data, 32'h12345678); else passes++;
  endtask

  initial begin
    checks = 0; passes = 0;
    rst = 1'b0; we = 1'b0; wr_addr = '0; wr_data = '0;
    rs_addr = '0; rt_addr = '0; dbg_addr = '0;
    test_reset;
    test_write_read;
    test_zero;
    test_same_cycle;
    test_reset_collision;
    test_boundary;
    test_back_to_back;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
